// File: rtl/ram_frame_reader.sv
// ram_frame_reader: streams a block of words from a latency-RD_LAT RAM read port onto a
// valid/ready stream with a credit-limited skid FIFO. Define RAM_FRAME_READER_TLAST_EN to drive m_tlast.
module ram_frame_reader #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_ren_b,
  output logic [ADDR_W-1:0] ram_raddr_b,
  input  logic [DATA_W-1:0] ram_rdata_b,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CREDIT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [CW-1:0] popcnt(input logic [RD_LAT-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t            state_r;
  logic [ADDR_W:0]   rem_r;
  logic              ren_r;
  logic [ADDR_W-1:0] raddr_r;
  logic              busy_r;
  logic              done_r;
  logic [RD_LAT-1:0] vld_sr_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     int_cnt_r;
  logic              tvalid_r;
  logic [DATA_W-1:0] tdata_r;

  logic              accept_s;
  logic              pop_s;
  logic              cap_s;
  logic              load_ok_s;
  logic              fifo_pop_s;
  logic              direct_s;
  logic              push_s;
  logic              out_load_s;
  logic [DATA_W-1:0] out_data_s;
  logic [RD_LAT-1:0] vld_nxt_s;
  logic [CW-1:0]     buf_cnt_s;
  logic [CW-1:0]     buf_nxt_s;
  logic [CW-1:0]     occ_nxt_s;
  logic              credit_s;
  logic              last_beat_s;

  // Handshake, capture routing and next-cycle occupancy used to pre-compute the registered read enable.
  always_comb begin
    accept_s    = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    pop_s       = tvalid_r && m_tready;
    cap_s       = vld_sr_r[RD_LAT-1];
    load_ok_s   = !tvalid_r || pop_s;
    fifo_pop_s  = load_ok_s && (int_cnt_r != {CW{1'b0}});
    direct_s    = load_ok_s && (int_cnt_r == {CW{1'b0}}) && cap_s;
    push_s      = cap_s && !direct_s;
    out_load_s  = fifo_pop_s || direct_s;
    if (fifo_pop_s) begin
      out_data_s = mem_r[rd_ptr_r];
    end else begin
      out_data_s = ram_rdata_b;
    end
    vld_nxt_s   = {vld_sr_r[RD_LAT-2:0], ren_r};
    buf_cnt_s   = {{(CW-1){1'b0}}, tvalid_r} + int_cnt_r;
    buf_nxt_s   = buf_cnt_s + {{(CW-1){1'b0}}, cap_s} - {{(CW-1){1'b0}}, pop_s};
    occ_nxt_s   = popcnt(vld_nxt_s) + buf_nxt_s;
    credit_s    = (occ_nxt_s < CREDIT);
    // With no reads left to issue, a pop that empties everything is the final beat.
    last_beat_s = pop_s && (vld_sr_r == {RD_LAT{1'b0}}) && (int_cnt_r == {CW{1'b0}});
  end

  // Frame FSM with registered busy/done and read-issue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      rem_r   <= LEN_ZERO;
      ren_r   <= 1'b0;
      raddr_r <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s && (len != LEN_ZERO)) begin
            state_r <= S_READ;
            rem_r   <= len;
            raddr_r <= base_addr;
            ren_r   <= credit_s;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else if (accept_s) begin
            state_r <= S_DONE;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        S_READ: begin
          done_r <= 1'b0;
          if (ren_r) begin
            raddr_r <= raddr_r + ADDR_ONE;
            rem_r   <= rem_r - LEN_ONE;
          end
          if (ren_r && (rem_r == LEN_ONE)) begin
            state_r <= S_DRAIN;
            ren_r   <= 1'b0;
          end else begin
            ren_r <= credit_s;
          end
        end
        S_DRAIN: begin
          ren_r <= 1'b0;
          if (last_beat_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ren_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Return tracking, skid FIFO pointers and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_r  <= {RD_LAT{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      int_cnt_r <= {CW{1'b0}};
      tvalid_r  <= 1'b0;
      tdata_r   <= {DATA_W{1'b0}};
    end else begin
      vld_sr_r  <= vld_nxt_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      int_cnt_r <= int_cnt_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, fifo_pop_s};
      if (out_load_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= out_data_s;
      end else if (pop_s) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  // Skid FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ram_rdata_b;
    end
  end

`ifdef RAM_FRAME_READER_TLAST_EN
  logic [ADDR_W:0] beats_left_r;
  logic            tlast_r;

  // Beat counter: marks the final word as it enters the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left_r <= LEN_ZERO;
      tlast_r      <= 1'b0;
    end else if (accept_s) begin
      beats_left_r <= len;
      tlast_r      <= 1'b0;
    end else if (out_load_s) begin
      beats_left_r <= beats_left_r - LEN_ONE;
      tlast_r      <= (beats_left_r == LEN_ONE);
    end else if (pop_s) begin
      tlast_r <= 1'b0;
    end
  end

  assign m_tlast = tlast_r;
`else
  assign m_tlast = 1'b0;
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign ram_ren_b   = ren_r;
  assign ram_raddr_b = raddr_r;
  assign m_tvalid    = tvalid_r;
  assign m_tdata     = tdata_r;

endmodule

// File: tb/tb_ram_frame_reader.sv
// Bench for ram_frame_reader: table of frames plus reset and back-to-back sequences,
// with a behavioural latency-2 RAM holding mem[a] = a and a queue scoreboard.
module tb_ram_frame_reader;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
`ifdef RAM_FRAME_READER_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif
  localparam int LIMIT = 400;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    int                mode;
    int                poke;
    int                exp_done;
    int                exp_first;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy;
  logic              done;
  logic              ram_ren_b;
  logic [ADDR_W-1:0] ram_raddr_b;
  logic [DATA_W-1:0] ram_rdata_b = '0;
  logic [DATA_W-1:0] ram_s1 = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vt[7];

  ram_frame_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .ram_ren_b   (ram_ren_b),
    .ram_raddr_b (ram_raddr_b),
    .ram_rdata_b (ram_rdata_b),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast)
  );

  always #5 clk = ~clk;

  // Read port with two register stages, preloaded so that mem[a] = a.
  always @(posedge clk) begin
    if (ram_ren_b) ram_s1 <= DATA_W'(ram_raddr_b);
    ram_rdata_b <= ram_s1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      default: return ($urandom_range(0, 1) != 0);
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   busy,        0);
    chk({tag, "_done"},   done,        0);
    chk({tag, "_ren"},    ram_ren_b,   0);
    chk({tag, "_raddr"},  ram_raddr_b, 0);
    chk({tag, "_tvalid"}, m_tvalid,    0);
    chk({tag, "_tdata"},  m_tdata,     0);
    chk({tag, "_tlast"},  m_tlast,     0);
  endtask

  task automatic idle_check();
    step();
    chk("idle_done",   done,     0);
    chk("idle_busy",   busy,     0);
    chk("idle_tvalid", m_tvalid, 0);
  endtask

  // Drives start in the current cycle (cycle 0) and runs until done or the cycle limit.
  task automatic run_frame(input vec_t v);
    int                issued, popped, max_occ, first_b, last_b, done_c;
    logic              hold;
    logic [DATA_W-1:0] hold_d;
    logic [ADDR_W-1:0] a;
    exp_t              e;
    issued = 0; popped = 0; max_occ = 0; first_b = -1; last_b = -1; done_c = -1;
    hold = 1'b0; hold_d = '0;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + ADDR_W'(i);
      e.data = DATA_W'(a);
      e.last = TLAST_EN && (i == int'(v.len) - 1);
      exp_q.push_back(e);
    end
    start = 1'b1; base_addr = v.base; len = v.len; m_tready = rdy(v.mode, 0);
    for (int cyc = 1; cyc <= LIMIT && done_c < 0; cyc++) begin
      step();
      start = (cyc == v.poke);
      if (start) begin
        base_addr = 17'h05555;
        len = 18'd3;
      end
      m_tready = rdy(v.mode, cyc);
      if (cyc == 1) begin
        chk("busy_cycle1", busy, (v.len != 0));
        chk("ren_cycle1", ram_ren_b, (v.len != 0));
      end
      if (ram_ren_b) begin
        a = v.base + ADDR_W'(issued);
        chk("raddr", ram_raddr_b, a);
        issued++;
        if (issued - popped > max_occ) max_occ = issued - popped;
      end
      if (hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, hold_d);
      end
      hold = m_tvalid && !m_tready;
      hold_d = m_tdata;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data 0x%0h expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.data);
          chk("beat_last", m_tlast, e.last);
        end
        popped++;
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
      end
      if (done) done_c = cyc;
    end
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", LIMIT);
    end
    if (v.exp_done >= 0) chk("done_cycle", done_c, v.exp_done);
    chk("busy_at_done", busy, 0);
    chk("reads_issued", issued, v.len);
    chk("beats", popped, v.len);
    chk("queue_empty", exp_q.size(), 0);
    chk("max_outstanding_le4", (max_occ <= 4), 1);
    if (v.exp_first >= 0) begin
      chk("first_beat_cycle", first_b, v.exp_first);
      chk("last_beat_cycle", last_b, v.exp_first + int'(v.len) - 1);
    end
    exp_q.delete();
  endtask

  initial begin
    vt[0] = '{17'h00010, 18'd8,  0, 0, 12, 4};
    vt[1] = '{17'h1FFFE, 18'd4,  0, 0, 8,  4};
    vt[2] = '{17'h00020, 18'd16, 1, 0, -1, -1};
    vt[3] = '{17'h00000, 18'd0,  0, 0, 1,  -1};
    vt[4] = '{17'h00040, 18'd6,  0, 3, 10, 4};
    vt[5] = '{17'h1FFF0, 18'd20, 2, 0, -1, -1};
    vt[6] = '{17'h000AB, 18'd1,  0, 0, 5,  4};

    rst = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_frame(vt[i]);
      idle_check();
    end

    // Reset in cycle 6 of a len-32 frame held under backpressure.
    start = 1'b1; base_addr = 17'h00100; len = 18'd32; m_tready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_tvalid", m_tvalid, 1);
    rst = 1'b1;
    step();
    check_zero("mid_reset");
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_reset_done", done, 0);
      chk("post_reset_tvalid", m_tvalid, 0);
    end
    run_frame('{17'h00000, 18'd2, 0, 0, 6, 4});
    idle_check();

    // Second start issued in the done cycle of the first frame.
    run_frame('{17'h00200, 18'd3, 0, 0, 7, 4});
    run_frame('{17'h00300, 18'd2, 0, 0, 6, 4});
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
